// File: rtl/vga_pkg.sv
// Shared types and default sizes for the SRAM arbiter and its video prefetch FIFO.
package vga_pkg;

    localparam int unsigned DEF_ADDR_WIDTH    = 17;
    localparam int unsigned DEF_DATA_WIDTH    = 8;
    localparam int unsigned DEF_CLIENTS       = 2;
    localparam int unsigned DEF_FIFO_DEPTH    = 16;
    localparam int unsigned DEF_ACCESS_CYCLES = 2;

    // Wide enough for the largest supported client count (8).
    localparam int unsigned CLIENT_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    typedef struct packed {
        logic                    video;
        logic [CLIENT_IDX_W-1:0] client;
    } grant_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Video prefetch FIFO: registered storage, combinational head, flush beats push and pop.
module prefetch_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            push,
    input  logic [DATA_WIDTH-1:0]           push_data,
    input  logic                            pop,
    output logic [DATA_WIDTH-1:0]           head,
    output logic [$clog2(FIFO_DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_q;
    logic [PTR_W-1:0]      rd_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_W'(FIFO_DEPTH)) || do_pop);

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush && !reset) mem_q[wr_q] <= push_data;
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between a prefetching video stream and round-robin host ports.
module sram_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned CLIENTS       = DEF_CLIENTS,
    parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                videoStart,
    input  logic [ADDR_WIDTH-1:0]               videoStartAddress,
    input  logic                                videoPop,
    output logic [DATA_WIDTH-1:0]               videoData,
    output logic                                videoDataValid,
    output logic                                videoUnderflow,
    input  logic [CLIENTS-1:0]                  clientRequest,
    input  logic [CLIENTS-1:0]                  clientWrite,
    input  logic [CLIENTS-1:0][ADDR_WIDTH-1:0]  clientAddress,
    input  logic [CLIENTS-1:0][DATA_WIDTH-1:0]  clientWriteData,
    output logic [DATA_WIDTH-1:0]               clientReadData,
    output logic [CLIENTS-1:0]                  clientComplete,
    output logic [ADDR_WIDTH-1:0]               ramAddress,
    output logic [DATA_WIDTH-1:0]               ramDataOut,
    input  logic [DATA_WIDTH-1:0]               ramDataIn,
    output logic                                ramDataOutEnable,
    output logic                                ramWriteEnable,
    output logic                                ramOutputEnable
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ACC_W = $clog2(ACCESS_CYCLES);
    localparam int unsigned IW    = CLIENT_IDX_W + 1;
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(FIFO_DEPTH / 2);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);

    arb_state_t              state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    grant_t                  grant_q, grant_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   cap_q, cap_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   vptr_q, vptr_d;
    logic                    ven_q, ven_d;
    logic                    discard_q, discard_d;
    logic [CLIENT_IDX_W-1:0] rr_q, rr_d;
    logic                    underflow_q, underflow_d;

    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_push;
    logic [CNT_W-1:0]        level;
    logic                    vid_en;
    logic [ADDR_WIDTH-1:0]   vid_addr;
    logic                    found;
    logic [CLIENT_IDX_W-1:0] pick;
    logic [IW-1:0]           cand;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    sel_write;

    prefetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (videoStart),
        .push      (fifo_push),
        .push_data (cap_q),
        .pop       (videoPop && !videoStart),
        .head      (videoData),
        .count     (fifo_count)
    );

    // A start in IDLE is treated as flush-then-grant, so the restarted stream is urgent at once.
    assign vid_en   = ven_q || videoStart;
    assign vid_addr = videoStart ? videoStartAddress : vptr_q;
    assign level    = (videoStart ? '0 : fifo_count)
                    + CNT_W'((state_q != IDLE) && grant_q.video && !discard_q);

    always_comb begin
        found     = 1'b0;
        pick      = '0;
        cand      = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int k = 0; k < CLIENTS; k++) begin
            cand = {1'b0, rr_q} + IW'(k);
            if (cand >= IW'(CLIENTS)) cand = cand - IW'(CLIENTS);
            for (int j = 0; j < CLIENTS; j++) begin
                if (!found && cand == IW'(j) && clientRequest[j]) begin
                    found     = 1'b1;
                    pick      = CLIENT_IDX_W'(j);
                    sel_addr  = clientAddress[j];
                    sel_wdata = clientWriteData[j];
                    sel_write = clientWrite[j];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        grant_d     = grant_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cap_d       = cap_q;
        rdata_d     = rdata_q;
        vptr_d      = vptr_q;
        ven_d       = ven_q;
        discard_d   = discard_q;
        rr_d        = rr_q;
        underflow_d = underflow_q;
        fifo_push   = 1'b0;

        case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (vid_en && level < HALF) begin
                    grant_d = '{video: 1'b1, client: '0};
                    state_d = ACCESS;
                end else if (found) begin
                    grant_d = '{video: 1'b0, client: pick};
                    rr_d    = (pick == CLIENT_IDX_W'(CLIENTS - 1)) ? '0 : pick + 1'b1;
                    state_d = ACCESS;
                end else if (vid_en && level < FULL) begin
                    grant_d = '{video: 1'b1, client: '0};
                    state_d = ACCESS;
                end
                if (state_d == ACCESS) begin
                    acc_d = '0;
                    if (grant_d.video) begin
                        addr_d  = vid_addr;
                        write_d = 1'b0;
                    end else begin
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                        write_d = sel_write;
                    end
                end
            end
            ACCESS: begin
                if (acc_q == ACC_LAST) begin
                    state_d = DONE;
                    if (!write_q) begin
                        if (grant_q.video) cap_d = ramDataIn;
                        else               rdata_d = ramDataIn;
                    end
                end else begin
                    acc_d = acc_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (grant_q.video && !discard_q && !videoStart) begin
                    fifo_push = 1'b1;
                    vptr_d    = vptr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (videoStart) begin
            ven_d       = 1'b1;
            vptr_d      = videoStartAddress;
            underflow_d = 1'b0;
            discard_d   = (state_q != IDLE);
        end else if (videoPop && !videoDataValid) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            grant_q     <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cap_q       <= '0;
            rdata_q     <= '0;
            vptr_q      <= '0;
            ven_q       <= 1'b0;
            discard_q   <= 1'b0;
            rr_q        <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            grant_q     <= grant_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cap_q       <= cap_d;
            rdata_q     <= rdata_d;
            vptr_q      <= vptr_d;
            ven_q       <= ven_d;
            discard_q   <= discard_d;
            rr_q        <= rr_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        for (int i = 0; i < CLIENTS; i++) begin
            clientComplete[i] = (state_q == DONE) && !grant_q.video
                              && (grant_q.client == CLIENT_IDX_W'(i));
        end
    end

    // Write strobe rises on the last access cycle so data is held past the WE edge.
    assign ramAddress       = addr_q;
    assign ramDataOut       = wdata_q;
    assign ramOutputEnable  = !((state_q == ACCESS) && !write_q);
    assign ramDataOutEnable = (state_q == ACCESS) && write_q;
    assign ramWriteEnable   = !((state_q == ACCESS) && write_q && (acc_q != ACC_LAST));
    assign clientReadData   = rdata_q;
    assign videoDataValid   = (fifo_count != '0);
    assign videoUnderflow   = underflow_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scenario bench for sram_arbiter with a behavioural SRAM and expected-value queues.
module tb_sram_arbiter;

    localparam int AW = 17;
    localparam int DW = 8;
    localparam int NC = 2;

    logic                   clock;
    logic                   reset;
    logic                   videoStart;
    logic [AW-1:0]          videoStartAddress;
    logic                   videoPop;
    logic [DW-1:0]          videoData;
    logic                   videoDataValid;
    logic                   videoUnderflow;
    logic [NC-1:0]          clientRequest;
    logic [NC-1:0]          clientWrite;
    logic [NC-1:0][AW-1:0]  clientAddress;
    logic [NC-1:0][DW-1:0]  clientWriteData;
    logic [DW-1:0]          clientReadData;
    logic [NC-1:0]          clientComplete;
    logic [AW-1:0]          ramAddress;
    logic [DW-1:0]          ramDataOut;
    logic [DW-1:0]          ramDataIn;
    logic                   ramDataOutEnable;
    logic                   ramWriteEnable;
    logic                   ramOutputEnable;

    sram_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .CLIENTS       (NC),
        .FIFO_DEPTH    (16),
        .ACCESS_CYCLES (2)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .videoStart        (videoStart),
        .videoStartAddress (videoStartAddress),
        .videoPop          (videoPop),
        .videoData         (videoData),
        .videoDataValid    (videoDataValid),
        .videoUnderflow    (videoUnderflow),
        .clientRequest     (clientRequest),
        .clientWrite       (clientWrite),
        .clientAddress     (clientAddress),
        .clientWriteData   (clientWriteData),
        .clientReadData    (clientReadData),
        .clientComplete    (clientComplete),
        .ramAddress        (ramAddress),
        .ramDataOut        (ramDataOut),
        .ramDataIn         (ramDataIn),
        .ramDataOutEnable  (ramDataOutEnable),
        .ramWriteEnable    (ramWriteEnable),
        .ramOutputEnable   (ramOutputEnable)
    );

    typedef struct {
        int          id;
        logic [7:0]  data;
        bit          is_read;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  vid_q[$];
    int          checks = 0;
    int          errors = 0;

    // Behavioural SRAM with a bench-side preload port.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clock) begin
        if (pre_en) sram[pre_addr] <= pre_data;
        else if (!ramWriteEnable && ramDataOutEnable) sram[ramAddress] <= ramDataOut;
    end

    assign ramDataIn = !ramOutputEnable ? sram[ramAddress] : '0;

    // Bus monitor: write-strobe cycle count and the address of every new access.
    int            we_low_total = 0;
    logic [AW-1:0] acc_log[$];
    logic          prev_active = 1'b0;

    always begin
        @(posedge clock);
        #2;
        if (!ramWriteEnable) we_low_total = we_low_total + 1;
        if ((!ramOutputEnable || ramDataOutEnable) && !prev_active) acc_log.push_back(ramAddress);
        prev_active = !ramOutputEnable || ramDataOutEnable;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(posedge clock);
        #1;
        pre_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        videoStart      = 1'b0;
        videoPop        = 1'b0;
        clientRequest   = '0;
        clientWrite     = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_complete(input int limit, output int cyc);
        cyc = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clock);
            if (clientComplete != '0) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (videoDataValid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            checks++;
            if (ramWriteEnable !== 1'b1 || ramOutputEnable !== 1'b1 || ramDataOutEnable !== 1'b0
                || clientComplete !== '0) begin
                errors++;
                $display("FAIL idle_pins cycle %0d: got we=%b oe=%b doe=%b cc=%b required we=1 oe=1 doe=0 cc=00",
                         c, ramWriteEnable, ramOutputEnable, ramDataOutEnable, clientComplete);
            end
        end
        checks++;
        if (ramAddress !== '0 || ramDataOut !== '0 || clientReadData !== '0) begin
            errors++;
            $display("FAIL reset_regs: got addr=%h dout=%h rdata=%h required 0 0 0",
                     ramAddress, ramDataOut, clientReadData);
        end
        checks++;
        if (videoDataValid !== 1'b0 || videoUnderflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_video: got valid=%b underflow=%b required 0 0",
                     videoDataValid, videoUnderflow);
        end
    endtask

    task automatic test_write_read();
        int   cyc;
        int   we0;
        exp_t e;
        do_reset();
        @(negedge clock);
        we0                = we_low_total;
        clientAddress[0]   = 17'h00010;
        clientWriteData[0] = 8'hA5;
        clientWrite        = 2'b01;
        clientRequest      = 2'b01;
        e.id = 0; e.data = 8'hA5; e.is_read = 1'b0;
        sb_q.push_back(e);
        wait_complete(20, cyc);
        e = sb_q.pop_front();
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL write_latency: got %0d required 3", cyc);
        end
        checks++;
        if (clientComplete !== NC'(1 << e.id)) begin
            errors++;
            $display("FAIL write_complete: got %b required %b", clientComplete, NC'(1 << e.id));
        end
        clientRequest = '0;
        checks++;
        if (we_low_total - we0 !== 1) begin
            errors++;
            $display("FAIL write_strobe_cycles: got %0d required 1", we_low_total - we0);
        end
        @(negedge clock);
        clientWrite   = 2'b00;
        clientRequest = 2'b01;
        e.id = 0; e.data = 8'hA5; e.is_read = 1'b1;
        sb_q.push_back(e);
        wait_complete(20, cyc);
        e = sb_q.pop_front();
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL read_latency: got %0d required 3", cyc);
        end
        checks++;
        if (clientComplete !== NC'(1 << e.id) || clientReadData !== e.data) begin
            errors++;
            $display("FAIL read_data: got cc=%b data=%h required cc=%b data=%h",
                     clientComplete, clientReadData, NC'(1 << e.id), e.data);
        end
        clientRequest = '0;
    endtask

    task automatic test_round_robin();
        int   cyc;
        int   rr;
        exp_t e;
        do_reset();
        preload(17'h00100, 8'h5A);
        preload(17'h00200, 8'hC3);
        rr = 0;
        for (int n = 0; n < 4; n++) begin
            e.id = rr; e.data = (rr == 0) ? 8'h5A : 8'hC3; e.is_read = 1'b1;
            sb_q.push_back(e);
            rr = (rr + 1) % NC;
        end
        @(negedge clock);
        clientAddress[0] = 17'h00100;
        clientAddress[1] = 17'h00200;
        clientWrite      = 2'b00;
        clientRequest    = 2'b11;
        for (int n = 0; n < 4; n++) begin
            wait_complete(20, cyc);
            e = sb_q.pop_front();
            checks++;
            if (cyc !== ((n == 0) ? 3 : 4)) begin
                errors++;
                $display("FAIL rr_spacing[%0d]: got %0d required %0d", n, cyc, (n == 0) ? 3 : 4);
            end
            checks++;
            if (clientComplete !== NC'(1 << e.id) || clientReadData !== e.data) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got cc=%b data=%h required cc=%b data=%h",
                         n, clientComplete, clientReadData, NC'(1 << e.id), e.data);
            end
        end
        clientRequest = '0;
    endtask

    task automatic test_video_wrap();
        bit         ok;
        int         bad;
        logic [7:0] exp8;
        do_reset();
        preload(17'h1FFFE, 8'h11);
        preload(17'h1FFFF, 8'h22);
        preload(17'h00000, 8'h33);
        vid_q.push_back(8'h11);
        vid_q.push_back(8'h22);
        vid_q.push_back(8'h33);
        @(negedge clock);
        videoStartAddress = 17'h1FFFE;
        videoStart        = 1'b1;
        @(negedge clock);
        videoStart        = 1'b0;
        for (int n = 0; n < 3; n++) begin
            wait_valid(40, ok);
            exp8 = vid_q.pop_front();
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL wrap_valid[%0d]: got no data within 40 cycles required valid", n);
            end else begin
                checks++;
                if (videoData !== exp8) begin
                    errors++;
                    $display("FAIL wrap_data[%0d]: got %h required %h", n, videoData, exp8);
                end
                videoPop = 1'b1;
                @(negedge clock);
                videoPop = 1'b0;
            end
        end
        repeat (100) @(negedge clock);
        checks++;
        if (videoDataValid !== 1'b1) begin
            errors++;
            $display("FAIL full_valid: got %b required 1", videoDataValid);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (ramOutputEnable !== 1'b1 || ramDataOutEnable !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL full_no_grant: got %0d busy cycles required 0", bad);
        end
    endtask

    task automatic test_urgent();
        int         cyc;
        int         base;
        bit         ok;
        logic [7:0] exp8;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            preload(17'h01000 + AW'(i), 8'h40 + 8'(i));
            vid_q.push_back(8'h40 + 8'(i));
        end
        preload(17'h00100, 8'h5A);
        @(negedge clock);
        base              = acc_log.size();
        clientAddress[0]  = 17'h00100;
        clientAddress[1]  = 17'h00200;
        clientWrite       = 2'b00;
        clientRequest     = 2'b11;
        videoStartAddress = 17'h01000;
        videoStart        = 1'b1;
        @(negedge clock);
        videoStart        = 1'b0;
        wait_complete(80, cyc);
        checks++;
        if (cyc < 0 || clientComplete !== 2'b01) begin
            errors++;
            $display("FAIL urgent_first_client: got cyc=%0d cc=%b required completion cc=01",
                     cyc, clientComplete);
        end
        clientRequest = '0;
        checks++;
        if (acc_log.size() < base + 9) begin
            errors++;
            $display("FAIL urgent_log_len: got %0d accesses required >= 9", acc_log.size() - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (acc_log[base + i] !== 17'h01000 + AW'(i)) begin
                    errors++;
                    $display("FAIL urgent_order[%0d]: got %h required %h",
                             i, acc_log[base + i], 17'h01000 + AW'(i));
                end
            end
            checks++;
            if (acc_log[base + 8] !== 17'h00100) begin
                errors++;
                $display("FAIL urgent_client_after: got %h required 00100", acc_log[base + 8]);
            end
        end
        for (int n = 0; n < 8; n++) begin
            wait_valid(40, ok);
            exp8 = vid_q.pop_front();
            checks++;
            if (!ok || videoData !== exp8) begin
                errors++;
                $display("FAIL urgent_data[%0d]: got valid=%b data=%h required valid=1 data=%h",
                         n, videoDataValid, videoData, exp8);
            end
            videoPop = ok;
            @(negedge clock);
            videoPop = 1'b0;
        end
    endtask

    task automatic test_underflow_flush();
        bit         ok;
        int         bad;
        logic [7:0] exp8;
        do_reset();
        preload(17'h02000, 8'h99);
        preload(17'h02001, 8'h9A);
        preload(17'h03000, 8'h77);
        preload(17'h03001, 8'h78);
        vid_q.push_back(8'h77);
        vid_q.push_back(8'h78);
        @(negedge clock);
        videoStartAddress = 17'h02000;
        videoStart        = 1'b1;
        @(negedge clock);
        videoStart        = 1'b0;
        checks++;
        if (videoDataValid !== 1'b0) begin
            errors++;
            $display("FAIL empty_after_start: got valid=%b required 0", videoDataValid);
        end
        videoPop = 1'b1;
        @(negedge clock);
        checks++;
        if (videoUnderflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_set: got %b required 1", videoUnderflow);
        end
        checks++;
        if (ramOutputEnable !== 1'b0) begin
            errors++;
            $display("FAIL inflight_read: got oe=%b required 0", ramOutputEnable);
        end
        // Restart while the 0x2000 read is on the bus, with a pop asserted alongside.
        videoStartAddress = 17'h03000;
        videoStart        = 1'b1;
        @(negedge clock);
        videoStart        = 1'b0;
        videoPop          = 1'b0;
        checks++;
        if (videoUnderflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: got %b required 0", videoUnderflow);
        end
        for (int n = 0; n < 2; n++) begin
            wait_valid(40, ok);
            exp8 = vid_q.pop_front();
            checks++;
            if (!ok || videoData !== exp8) begin
                errors++;
                $display("FAIL flush_data[%0d]: got valid=%b data=%h required valid=1 data=%h",
                         n, videoDataValid, videoData, exp8);
            end
            videoPop = ok;
            @(negedge clock);
            videoPop = 1'b0;
        end
        videoStart = 1'b1;
        @(negedge clock);
        videoStart = 1'b0;
        videoPop   = 1'b1;
        @(negedge clock);
        videoPop   = 1'b0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (videoUnderflow !== 1'b1) bad++;
            @(negedge clock);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL underflow_sticky: got %0d cycles clear required 0", bad);
        end
    endtask

    task automatic test_reset_mid_access();
        int bad;
        do_reset();
        @(negedge clock);
        clientAddress[0]   = 17'h00020;
        clientWriteData[0] = 8'h3C;
        clientWrite        = 2'b01;
        clientRequest      = 2'b01;
        @(negedge clock);
        checks++;
        if (ramDataOutEnable !== 1'b1 || ramWriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL mid_access_drive: got doe=%b we=%b required 1 0",
                     ramDataOutEnable, ramWriteEnable);
        end
        reset         = 1'b1;
        clientRequest = '0;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (ramDataOutEnable !== 1'b0 || ramWriteEnable !== 1'b1 || ramOutputEnable !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got doe=%b we=%b oe=%b required 0 1 1",
                     ramDataOutEnable, ramWriteEnable, ramOutputEnable);
        end
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (clientComplete !== '0) bad++;
            @(negedge clock);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_no_complete: got %0d pulses required 0", bad);
        end
    endtask

    initial begin
        reset             = 1'b1;
        videoStart        = 1'b0;
        videoStartAddress = '0;
        videoPop          = 1'b0;
        clientRequest     = '0;
        clientWrite       = '0;
        clientAddress     = '0;
        clientWriteData   = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_video_wrap();
        test_urgent();
        test_underflow_flush();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
